// File: rtl/rdid_checker.sv
// rdid_checker: triggers an RDID read on the flash SPI master, snoops the
// transfer to capture the 24-bit JEDEC ID, compares it with EXPECTED_ID and
// retries on mismatch, early chip-select release or stalled SPI activity.
module rdid_checker #(
   parameter logic [23:0] EXPECTED_ID    = 24'h202015,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          MAX_RETRIES    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        spisck,
   input  logic        spimiso,
   input  logic        prom_cs_n,
   output logic        get_rdid,
   output logic [23:0] id_data,
   output logic        id_valid,
   output logic        pass,
   output logic        fail,
   output logic        busy,
   output logic [1:0]  retry_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE, TRIGGER, WAIT_CS, SHIFT, WAIT_DONE, CHECK, DONE
   } state_t;

   state_t        state;
   logic          sck_d;
   logic          sck_rise;
   logic [5:0]    edge_cnt;
   logic [23:0]   shreg;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          retry_req;

   assign busy = (state != IDLE);

   // Delay the snooped SPI clock one cycle for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sck_d <= 1'b0;
      else     sck_d <= spisck;
   end

   // Decide whether the current attempt has failed and must take the retry path
   always_comb begin
      sck_rise  = spisck & ~sck_d;
      tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYCLES));
      retry_req = 1'b0;
      case (state)
         WAIT_CS:   retry_req = prom_cs_n & tmo_hit;
         SHIFT:     retry_req = prom_cs_n | (tmo_hit & ~sck_rise);
         WAIT_DONE: retry_req = ~prom_cs_n & tmo_hit;
         CHECK:     retry_req = (id_data != EXPECTED_ID);
         default:   retry_req = 1'b0;
      endcase
   end

   // Main control FSM with registered outputs and datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         get_rdid    <= 1'b0;
         id_valid    <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         retry_count <= 2'd0;
         id_data     <= 24'h0;
         shreg       <= 24'h0;
         edge_cnt    <= 6'd0;
         tmo_cnt     <= '0;
      end else begin
         get_rdid <= 1'b0;
         id_valid <= 1'b0;
         tmo_cnt  <= tmo_cnt + TW'(1);
         if (retry_req) begin
            tmo_cnt <= '0;
            if (int'(retry_count) < MAX_RETRIES) begin
               retry_count <= retry_count + 2'd1;
               state       <= TRIGGER;
               // a retry only fires once the flash is deselected
               get_rdid    <= prom_cs_n;
            end else begin
               fail  <= 1'b1;
               state <= DONE;
            end
         end else begin
            case (state)
               IDLE: begin
                  tmo_cnt <= '0;
                  if (start) begin
                     pass        <= 1'b0;
                     fail        <= 1'b0;
                     retry_count <= 2'd0;
                     state       <= TRIGGER;
                     get_rdid    <= prom_cs_n;
                  end
               end
               TRIGGER: begin
                  // hold here until chip select is high, pulse get_rdid once
                  tmo_cnt <= '0;
                  if (get_rdid) state <= WAIT_CS;
                  else          get_rdid <= prom_cs_n;
               end
               WAIT_CS: begin
                  if (sck_rise) tmo_cnt <= '0;
                  if (!prom_cs_n) begin
                     state    <= SHIFT;
                     tmo_cnt  <= '0;
                     edge_cnt <= 6'd0;
                     shreg    <= 24'h0;
                  end
               end
               SHIFT: begin
                  if (sck_rise) begin
                     tmo_cnt  <= '0;
                     edge_cnt <= edge_cnt + 6'd1;
                     // first 8 edges carry the command byte
                     if (edge_cnt >= 6'd8) shreg <= {shreg[22:0], spimiso};
                     if (edge_cnt == 6'd31) state <= WAIT_DONE;
                  end
               end
               WAIT_DONE: begin
                  if (sck_rise) tmo_cnt <= '0;
                  if (prom_cs_n) begin
                     id_data  <= shreg;
                     id_valid <= 1'b1;
                     state    <= CHECK;
                  end
               end
               CHECK: begin
                  pass  <= 1'b1;
                  state <= DONE;
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rdid_checker.sv
// Bench for rdid_checker: a scripted SPI flash model answers each get_rdid,
// expected IDs and verdicts are queued at stimulus time and popped by a monitor.
module tb_rdid_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        spisck = 1'b0;
   logic        spimiso = 1'b0;
   logic        prom_cs_n = 1'b1;
   logic        get_rdid;
   logic [23:0] id_data;
   logic        id_valid;
   logic        pass;
   logic        fail;
   logic        busy;
   logic [1:0]  retry_count;

   typedef struct {
      logic [23:0] id;
      int          edges;   // 0 = never select the flash
   } item_t;

   typedef struct {
      logic       p;
      logic       f;
      logic [1:0] rc;
      int         trig;
   } verdict_t;

   item_t       resp_q[$];
   logic [23:0] exp_id_q[$];
   verdict_t    exp_v_q[$];

   int total = 0;
   int bad = 0;
   int trig_cnt = 0;
   int trig_base = 0;
   int verdict_cnt = 0;
   bit m_busy = 0;
   logic pass_q = 1'b0;
   logic fail_q = 1'b0;

   rdid_checker dut (
      .clk(clk), .rst(rst), .start(start), .spisck(spisck), .spimiso(spimiso),
      .prom_cs_n(prom_cs_n), .get_rdid(get_rdid), .id_data(id_data),
      .id_valid(id_valid), .pass(pass), .fail(fail), .busy(busy),
      .retry_count(retry_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // SPI master model: 8 command bits then 24 ID bits, MSB first
   task automatic run_xfer(input item_t it);
      logic [7:0] cmd;
      cmd = 8'h9F;
      if (it.edges == 0) return;
      m_busy = 1;
      prom_cs_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int e = 0; e < 32; e++) begin
         if (e == it.edges) break;
         spimiso = (e < 8) ? cmd[3'(7 - e)] : it.id[5'(31 - e)];
         repeat (2) @(negedge clk);
         spisck = 1'b1;
         repeat (2) @(negedge clk);
         spisck = 1'b0;
      end
      repeat (2) @(negedge clk);
      prom_cs_n = 1'b1;
      spimiso = 1'b0;
      m_busy = 0;
   endtask

   always begin
      @(negedge clk);
      if (get_rdid && resp_q.size() > 0) run_xfer(resp_q.pop_front());
   end

   // Monitor: count triggers, check captured IDs and verdicts
   always @(negedge clk) begin
      if (get_rdid) trig_cnt++;
      if (id_valid) begin
         if (exp_id_q.size() == 0) chk("unexpected_id_valid", 32'(id_data), 32'hDEAD);
         else chk("id_data", 32'(id_data), 32'(exp_id_q.pop_front()));
      end
      if ((pass && !pass_q) || (fail && !fail_q)) begin
         verdict_t v;
         if (exp_v_q.size() == 0) begin
            chk("unexpected_verdict", {30'd0, pass, fail}, 32'h0);
         end else begin
            v = exp_v_q.pop_front();
            chk("pass_fail", {30'd0, pass, fail}, {30'd0, v.p, v.f});
            chk("retry_count", 32'(retry_count), 32'(v.rc));
            chk("trigger_count", 32'(trig_cnt - trig_base), 32'(v.trig));
         end
         verdict_cnt++;
      end
      pass_q <= pass;
      fail_q <= fail;
   end

   task automatic do_start(input bit check_latency);
      @(negedge clk);
      trig_base = trig_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (check_latency) chk("get_rdid_latency", 32'(get_rdid), 32'h1);
   endtask

   task automatic wait_verdict(input int n, input int budget);
      int c;
      c = 0;
      while (verdict_cnt < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("verdict_timeout", 32'(verdict_cnt >= n), 32'h1);
      repeat (3) @(negedge clk);
   endtask

   task automatic push_xfer(input logic [23:0] id, input int edges, input bit expect_id);
      item_t it;
      it.id = id;
      it.edges = edges;
      resp_q.push_back(it);
      if (expect_id) exp_id_q.push_back(id);
   endtask

   task automatic push_verdict(input logic p, input logic f, input logic [1:0] rc, input int trig);
      verdict_t v;
      v.p = p; v.f = f; v.rc = rc; v.trig = trig;
      exp_v_q.push_back(v);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_get_rdid"}, 32'(get_rdid), 32'h0);
      chk({tag, "_id_valid"}, 32'(id_valid), 32'h0);
      chk({tag, "_pass"}, 32'(pass), 32'h0);
      chk({tag, "_fail"}, 32'(fail), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_retry_count"}, 32'(retry_count), 32'h0);
      chk({tag, "_id_data"}, 32'(id_data), 32'h0);
   endtask

   initial begin
      int c;
      // reset state
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // good ID on the first attempt
      push_xfer(24'h202015, 32, 1);
      push_verdict(1'b1, 1'b0, 2'd0, 1);
      do_start(1);
      wait_verdict(1, 1000);

      // persistent bad ID: all retries used, then fail
      for (int i = 0; i < 4; i++) push_xfer(24'hFFFFFF, 32, 1);
      push_verdict(1'b0, 1'b1, 2'd3, 4);
      do_start(1);
      wait_verdict(2, 3000);

      // transient: first attempt wrong, second correct
      push_xfer(24'h000000, 32, 1);
      push_xfer(24'h202015, 32, 1);
      push_verdict(1'b1, 1'b0, 2'd1, 2);
      do_start(1);
      wait_verdict(3, 2000);

      // stall: chip select never asserted, each attempt times out
      for (int i = 0; i < 4; i++) push_xfer(24'h0, 0, 0);
      push_verdict(1'b0, 1'b1, 2'd3, 4);
      do_start(1);
      wait_verdict(4, 3000);

      // early chip-select release after 20 edges, then a good ID
      push_xfer(24'h202015, 20, 0);
      push_xfer(24'h202015, 32, 1);
      push_verdict(1'b1, 1'b0, 2'd1, 2);
      do_start(1);
      wait_verdict(5, 2000);

      // near-miss ID exercises the comparator on a single bit
      for (int i = 0; i < 4; i++) push_xfer(24'h202014, 32, 1);
      push_verdict(1'b0, 1'b1, 2'd3, 4);
      do_start(0);
      wait_verdict(6, 3000);

      // reset in the middle of SHIFT: no verdict, no id_valid
      push_xfer(24'h202015, 32, 0);
      do_start(0);
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midreset");
      rst = 1'b0;
      c = 0;
      while (m_busy && c < 1000) begin
         @(negedge clk);
         c++;
      end
      chk("master_idle_timeout", 32'(m_busy), 32'h0);
      repeat (3) @(negedge clk);

      // fresh check after reset; start pulses while busy are ignored
      push_xfer(24'h202015, 32, 1);
      push_verdict(1'b1, 1'b0, 2'd0, 1);
      do_start(1);
      for (int i = 0; i < 5; i++) begin
         repeat (3) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_verdict(7, 1000);
      chk("final_id_data", 32'(id_data), 32'h202015);
      chk("busy_after_done", 32'(busy), 32'h0);
      chk("pending_ids", 32'(exp_id_q.size()), 32'h0);
      chk("pending_verdicts", 32'(exp_v_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rdid_checker.md
RDID_CHECKER -- requirements
Module: rdid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 24'h202015, is the expected {manufacturer, memory type, capacity} JEDEC ID.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of clk cycles allowed without SPI progress.
REQ-003 Parameter MAX_RETRIES, default 3, is the number of re-attempts allowed after the first failed attempt.
REQ-004 clk  input  1  system clock; reset rst, asynchronous, active-high; clock clk.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  single-cycle request to run one ID check.
REQ-007 spisck  input  1  SPI clock, snooped from the RDID master.
REQ-008 spimiso  input  1  flash serial data out, snooped.
REQ-009 prom_cs_n  input  1  flash chip select, active low, snooped.
REQ-010 get_rdid  output  1  one-cycle trigger to the RDID master.
REQ-011 id_data  output  24  last captured ID, MSB first on the wire.
REQ-012 id_valid  output  1  one-cycle pulse when id_data is updated.
REQ-013 pass / fail  output  1 each  sticky verdict; cleared on the next accepted start.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 retry_count  output  2  number of retries used in the current check.

Function
REQ-016 The state machine SHALL have the states IDLE, TRIGGER, WAIT_CS, SHIFT, WAIT_DONE, CHECK and DONE.
REQ-017 IDLE: on start=1, the block SHALL clear pass, fail and retry_count and go to TRIGGER; start SHALL be ignored in every other state.
REQ-018 TRIGGER: get_rdid SHALL be 1 for exactly this one cycle, then the block goes to WAIT_CS.
REQ-019 WAIT_CS: the block SHALL go to SHIFT on the first cycle with prom_cs_n=0; on a timeout it SHALL take the retry path.
REQ-020 spisck SHALL be registered each clk into sck_d; a rising edge is spisck=1 and sck_d=0.
REQ-021 SHIFT: a 6-bit edge counter SHALL count rising edges; edges 1-8 (the command byte) are ignored; on edges 9-32, spimiso SHALL be shifted into the LSB of a 24-bit shift register.
REQ-022 SHIFT: after edge 32 the block SHALL go to WAIT_DONE; if prom_cs_n rises before edge 32, the block SHALL take the retry path.
REQ-023 WAIT_DONE: on prom_cs_n=1, id_data SHALL load the shift register, id_valid SHALL pulse for 1 cycle, and the block goes to CHECK.
REQ-024 The timeout counter SHALL reset on entry to WAIT_CS, SHIFT and WAIT_DONE and on every spisck rising edge; when it reaches TIMEOUT_CYCLES in any of those states, the block SHALL take the retry path.
REQ-025 CHECK: if id_data == EXPECTED_ID, the block SHALL set pass=1 and go to DONE; otherwise it takes the retry path.
REQ-026 Retry path: if retry_count < MAX_RETRIES, the block SHALL increment retry_count and go to TRIGGER; otherwise it SHALL set fail=1 and go to DONE.
REQ-027 A retry SHALL NOT re-trigger until prom_cs_n=1 has been seen for at least 1 cycle (hold in TRIGGER's entry until then).
REQ-028 DONE: the block SHALL return to IDLE after 1 cycle; pass and fail SHALL NOT both be 1.
REQ-029 Latency: get_rdid SHALL assert exactly 1 clk after start is sampled; pass or fail SHALL assert 2 clk after prom_cs_n rises following edge 32.

Reset
REQ-030 On reset: state=IDLE; get_rdid=0, id_valid=0, pass=0, fail=0, busy=0, retry_count=0, id_data=24'h0; shift register, edge counter, timeout counter and sck_d=0.
REQ-031 A reset asserted mid-transaction SHALL abort immediately; no verdict is produced and the next start begins a fresh check.

Verification
REQ-032 Good ID: start, flash model returns 0x20,0x20,0x15 -> one get_rdid pulse, id_data=24'h202015, id_valid pulse, pass=1, retry_count=0.
REQ-033 Bad ID persistent: model returns 0xFFFFFF -> 4 get_rdid pulses total, retry_count=3, fail=1, pass=0.
REQ-034 Transient: first response 0x000000, second 0x202015 -> retry_count=1, pass=1.
REQ-035 Stall: prom_cs_n never asserts -> timeout after 255 cycles each attempt, 4 triggers, fail=1.
REQ-036 Early CS release after 20 edges -> retry taken, no id_valid for that attempt.
REQ-037 Reset during SHIFT, then start -> all outputs return to reset values, the next check completes normally, and start pulses while busy cause no extra get_rdid.
